// File: rtl/fir_input_sequencer_pkg.sv
// Shared types and constants for the FIR input sequencer.
//   DATA_W      : width of samples, coefficients and results
//   NUM_COEFF   : coefficients per set (F0..F3)
//   coeff_idx_t : index into the coefficient bank
//   seq_state_t : handshake sequencer states
package fir_seq_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_COEFF = 4;
  localparam int IDX_W     = 2;

  typedef logic [IDX_W-1:0] coeff_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_CH = 3'd2,
    ST_WAIT_CL = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_DH = 3'd5,
    ST_WAIT_DL = 3'd6,
    ST_CAPTURE = 3'd7
  } seq_state_t;

endpackage

// File: rtl/fir_input_sequencer_sample_fifo.sv
// Synchronous sample FIFO with registered full/empty flags.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write request and data (dropped while full)
//   pop      : read request (ignored while empty); head shows the oldest entry
//   full/empty : occupancy flags
//   overrun  : sticky, set by a push attempted while full
module sample_fifo
  import fir_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             overrun_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against the current flags and work out the next occupancy.
  always_comb begin
    push_ok_s = push & ~full_r;
    pop_ok_s  = pop & ~empty_r;
    cnt_nxt_s = cnt_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Storage, pointers, occupancy and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      cnt_r     <= '0;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      overrun_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      cnt_r     <= cnt_nxt_s;
      full_r    <= (cnt_nxt_s == DEPTH_C);
      empty_r   <= (cnt_nxt_s == CNT_W'(0));
      overrun_r <= overrun_r | (push & full_r);
    end
  end

  assign head    = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign overrun = overrun_r;

endmodule

// File: rtl/fir_input_sequencer.sv
// Front end for the FIR filter: holds the coefficient bank and a sample FIFO,
// sequences the filter's load_coeff / data_ready handshakes off modwait edges,
// and parks each filter result in a valid/ack register.
//   coeff_wr/coeff_idx/coeff_in : bank write port (ignored while loading)
//   new_coeff_set               : request a bank load into the filter
//   sample_wr/sample_in         : FIFO push; sample_full/empty/overrun status
//   fir_coefficient/load_coeff  : coefficient handshake to the filter
//   sample_data/data_ready      : sample handshake to the filter
//   modwait/fir_out/err         : filter busy flag and result
//   result_data/err/valid/ack   : captured result to the consumer
//   coeff_loaded, timeout_err   : bank-loaded flag, sticky handshake timeout
module fir_input_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W     = fir_seq_pkg::DATA_W,
  parameter int NUM_COEFF  = fir_seq_pkg::NUM_COEFF,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coeff_wr,
  input  logic [1:0]        coeff_idx,
  input  logic [DATA_W-1:0] coeff_in,
  input  logic              new_coeff_set,
  input  logic              sample_wr,
  input  logic [DATA_W-1:0] sample_in,
  output logic              sample_full,
  output logic              sample_empty,
  output logic              overrun,
  output logic [DATA_W-1:0] fir_coefficient,
  output logic              load_coeff,
  output logic [DATA_W-1:0] sample_data,
  output logic              data_ready,
  input  logic              modwait,
  input  logic [DATA_W-1:0] fir_out,
  input  logic              err,
  output logic [DATA_W-1:0] result_data,
  output logic              result_err,
  output logic              result_valid,
  input  logic              result_ack,
  output logic              coeff_loaded,
  output logic              timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam coeff_idx_t       IDX_LAST = coeff_idx_t'(NUM_COEFF - 1);

  seq_state_t        state_r, state_nxt_s;
  logic [DATA_W-1:0] bank_r [NUM_COEFF];
  coeff_idx_t        idx_r, idx_nxt_s;
  logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_nxt_s;
  logic              pending_r, pending_nxt_s;
  logic              coeff_loaded_r, coeff_loaded_nxt_s;
  logic              timeout_err_r, timeout_err_nxt_s;
  logic              load_coeff_r, load_coeff_nxt_s;
  logic              data_ready_r, data_ready_nxt_s;
  logic [DATA_W-1:0] fir_coefficient_r, fir_coefficient_nxt_s;
  logic [DATA_W-1:0] sample_data_r, sample_data_nxt_s;
  logic              result_valid_r;
  logic [DATA_W-1:0] result_data_r;
  logic              result_err_r;
  logic              capture_s;
  logic              fifo_pop_s;
  logic              bank_wr_ok_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic              fifo_empty_s;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_sample_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (sample_wr),
    .din     (sample_in),
    .pop     (fifo_pop_s),
    .head    (fifo_head_s),
    .full    (sample_full),
    .empty   (fifo_empty_s),
    .overrun (overrun)
  );

  // Next-state and next-output logic for the handshake sequencer.
  always_comb begin
    state_nxt_s           = state_r;
    idx_nxt_s             = idx_r;
    tmo_cnt_nxt_s         = tmo_cnt_r;
    pending_nxt_s         = pending_r | new_coeff_set;
    coeff_loaded_nxt_s    = coeff_loaded_r;
    timeout_err_nxt_s     = timeout_err_r;
    load_coeff_nxt_s      = load_coeff_r;
    data_ready_nxt_s      = data_ready_r;
    fir_coefficient_nxt_s = fir_coefficient_r;
    sample_data_nxt_s     = sample_data_r;
    fifo_pop_s            = 1'b0;
    capture_s             = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A reload request outranks sample traffic.
        if (new_coeff_set || pending_r) begin
          pending_nxt_s      = 1'b0;
          coeff_loaded_nxt_s = 1'b0;
          idx_nxt_s          = '0;
          state_nxt_s        = ST_LOAD;
        end else if (coeff_loaded_r && !fifo_empty_s && !modwait) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        fir_coefficient_nxt_s = bank_r[idx_r];
        load_coeff_nxt_s      = 1'b1;
        tmo_cnt_nxt_s         = '0;
        state_nxt_s           = ST_WAIT_CH;
      end
      ST_WAIT_CH: begin
        if (modwait) begin
          load_coeff_nxt_s = 1'b0;
          state_nxt_s      = ST_WAIT_CL;
        end else if (tmo_cnt_r == TMO_LAST) begin
          timeout_err_nxt_s  = 1'b1;
          load_coeff_nxt_s   = 1'b0;
          coeff_loaded_nxt_s = 1'b0;
          state_nxt_s        = ST_IDLE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      ST_WAIT_CL: begin
        if (!modwait) begin
          if (idx_r == IDX_LAST) begin
            coeff_loaded_nxt_s = 1'b1;
            state_nxt_s        = ST_IDLE;
          end else begin
            idx_nxt_s   = idx_r + coeff_idx_t'(1);
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_WAIT_CL;
        end
      end
      ST_SEND: begin
        sample_data_nxt_s = fifo_head_s;
        data_ready_nxt_s  = 1'b1;
        fifo_pop_s        = 1'b1;
        tmo_cnt_nxt_s     = '0;
        state_nxt_s       = ST_WAIT_DH;
      end
      ST_WAIT_DH: begin
        // On timeout the sample has already been popped and is simply lost.
        if (modwait) begin
          data_ready_nxt_s = 1'b0;
          state_nxt_s      = ST_WAIT_DL;
        end else if (tmo_cnt_r == TMO_LAST) begin
          timeout_err_nxt_s = 1'b1;
          data_ready_nxt_s  = 1'b0;
          state_nxt_s       = ST_IDLE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      ST_WAIT_DL: begin
        if (!modwait) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_WAIT_DL;
        end
      end
      ST_CAPTURE: begin
        // Stall here while the previous result is still unacknowledged.
        if (!result_valid_r || result_ack) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      default: begin
        load_coeff_nxt_s = 1'b0;
        data_ready_nxt_s = 1'b0;
        state_nxt_s      = ST_IDLE;
      end
    endcase
  end

  // The bank must not change underneath an in-progress load.
  always_comb begin
    bank_wr_ok_s = 1'b0;
    case (state_r)
      ST_LOAD, ST_WAIT_CH, ST_WAIT_CL: bank_wr_ok_s = 1'b0;
      default:                         bank_wr_ok_s = coeff_wr;
    endcase
  end

  // Sequencer state and registered filter-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      idx_r             <= '0;
      tmo_cnt_r         <= '0;
      pending_r         <= 1'b0;
      coeff_loaded_r    <= 1'b0;
      timeout_err_r     <= 1'b0;
      load_coeff_r      <= 1'b0;
      data_ready_r      <= 1'b0;
      fir_coefficient_r <= '0;
      sample_data_r     <= '0;
    end else begin
      state_r           <= state_nxt_s;
      idx_r             <= idx_nxt_s;
      tmo_cnt_r         <= tmo_cnt_nxt_s;
      pending_r         <= pending_nxt_s;
      coeff_loaded_r    <= coeff_loaded_nxt_s;
      timeout_err_r     <= timeout_err_nxt_s;
      load_coeff_r      <= load_coeff_nxt_s;
      data_ready_r      <= data_ready_nxt_s;
      fir_coefficient_r <= fir_coefficient_nxt_s;
      sample_data_r     <= sample_data_nxt_s;
    end
  end

  // Coefficient bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEFF; i++) bank_r[i] <= '0;
    end else if (bank_wr_ok_s) begin
      bank_r[coeff_idx] <= coeff_in;
    end
  end

  // Result register: a capture refills it, otherwise an ack empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_valid_r <= 1'b0;
      result_data_r  <= '0;
      result_err_r   <= 1'b0;
    end else if (capture_s) begin
      result_valid_r <= 1'b1;
      result_data_r  <= fir_out;
      result_err_r   <= err;
    end else if (result_ack) begin
      result_valid_r <= 1'b0;
    end
  end

  assign sample_empty    = fifo_empty_s;
  assign fir_coefficient = fir_coefficient_r;
  assign load_coeff      = load_coeff_r;
  assign sample_data     = sample_data_r;
  assign data_ready      = data_ready_r;
  assign result_data     = result_data_r;
  assign result_err      = result_err_r;
  assign result_valid    = result_valid_r;
  assign coeff_loaded    = coeff_loaded_r;
  assign timeout_err     = timeout_err_r;

endmodule

// File: doc/fir_input_sequencer.md
Name: fir_input_sequencer

Overview:
- Sits directly upstream of the FIR filter top level.
- Holds a 4-entry coefficient bank and a small sample FIFO.
- Sequences the filter's load_coeff / data_ready handshakes using the filter's modwait as the busy indicator.
- Captures each fir_out / err into a result register with a valid/ack interface. This decouples a bus-side producer from the filter's multi-cycle processing.

Parameters:
DATA_W, 16, width of samples, coefficients and results
NUM_COEFF, 4, coefficients per set (F0..F3)
FIFO_DEPTH, 4, sample FIFO entries (power of 2)
TIMEOUT, 32, max cycles to wait for modwait to rise after a request

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
coeff_wr  in  1  write coeff_in into bank[coeff_idx]
coeff_idx  in  2  coefficient index
coeff_in  in  DATA_W  coefficient value
new_coeff_set  in  1  pulse: request (re)load of the bank into the filter
sample_wr  in  1  push sample_in into FIFO
sample_in  in  DATA_W  sample value
sample_full  out  1  FIFO full
sample_empty  out  1  FIFO empty
overrun  out  1  sticky: push attempted while full
fir_coefficient  out  DATA_W  coefficient to filter
load_coeff  out  1  coefficient-load request to filter
sample_data  out  DATA_W  sample to filter
data_ready  out  1  sample-ready request to filter
modwait  in  1  filter busy
fir_out  in  DATA_W  filter result
err  in  1  filter error
result_data  out  DATA_W  captured result
result_err  out  1  captured err
result_valid  out  1  result held, awaiting ack
result_ack  in  1  consumer accepts result
coeff_loaded  out  1  bank loaded since last reset/reload request
timeout_err  out  1  sticky: filter never raised modwait

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0.
  - FIFO empty, so sample_empty=1.
  - Bank cleared to 0; state IDLE.
  - Reset mid-handshake drops load_coeff/data_ready the next edge; a partial load leaves coeff_loaded=0.
- Bank: coeff_wr writes in any state except LOAD/WAIT_CH/WAIT_CL; writes in those states are ignored.
- FIFO:
  - Push when full is dropped and sets overrun.
  - Push and pop in the same cycle when not full both succeed; count unchanged.
  - Pop occurs only on the SEND→WAIT_DH transition.
- FSM states: IDLE, LOAD, WAIT_CH, WAIT_CL, SEND, WAIT_DH, WAIT_DL, CAPTURE.
  - IDLE:
    - new_coeff_set (or a pending latched request) has priority: clear coeff_loaded, idx=0, go to LOAD.
    - Else, if coeff_loaded and FIFO not empty and modwait=0, go to SEND.
  - LOAD: drive fir_coefficient=bank[idx], load_coeff=1; go to WAIT_CH.
  - WAIT_CH:
    - Hold load_coeff=1 until modwait=1, then drop load_coeff and go to WAIT_CL.
    - Timeout counter runs; on reaching TIMEOUT: set timeout_err, drop load_coeff, go to IDLE with coeff_loaded=0.
  - WAIT_CL:
    - On modwait=0: if idx=NUM_COEFF-1, set coeff_loaded and go to IDLE.
    - Else idx++ and go to LOAD.
  - SEND: drive sample_data=FIFO head, data_ready=1; pop; go to WAIT_DH. sample_data stays registered until the next SEND.
  - WAIT_DH: hold data_ready until modwait=1 (same timeout rule; on timeout the sample is discarded).
  - WAIT_DL: on modwait=0, go to CAPTURE.
  - CAPTURE:
    - If result_valid=0 or result_ack=1: latch result_data=fir_out, result_err=err, result_valid=1, go to IDLE.
    - Else stall (backpressure).
  - result_valid clears on result_ack when no capture occurs that cycle.
- new_coeff_set arriving outside IDLE is latched as pending; multiple pulses collapse to one.
- The filter's input synchronisers add ≥2 cycles before modwait responds. The design relies only on modwait edges, not fixed latency.

Decomposition:
- Package fir_seq_pkg: state enum type, DATA_W/NUM_COEFF constants, coefficient index type.
- Sub-module sample_fifo: parameterised synchronous FIFO with full/empty, producing overrun on a push while full.
- The FSM, bank and result register live in the top module.

Test Plan:
- Write bank {0x0001,0x0002,0x0003,0x0004}, pulse new_coeff_set, model filter raising modwait 3 cycles after each request for 4 cycles → fir_coefficient sequence 1,2,3,4; load_coeff drops the cycle after modwait=1; coeff_loaded=1 after the 4th modwait fall.
- Push samples 0x0010,0x0020 with coeffs loaded, filter returns fir_out=0x0100 then 0x0200 → sample_data 0x0010 then 0x0020; result_valid pulses with 0x0100, then 0x0200 after each ack.
- Push 5 samples while FIFO blocked (coeff_loaded=0) → sample_full after 4; overrun=1; 5th sample never sent.
- Withhold result_ack after the first result, 2 samples queued → FSM stalls in CAPTURE; second sample is not sent until ack; no result lost.
- Filter never raises modwait after data_ready → timeout_err=1 after 32 cycles; data_ready=0; FIFO count decremented by 1.
- Assert rst during WAIT_CH at coefficient 2 → next cycle load_coeff=0, coeff_loaded=0, sample_empty=1, result_valid=0.
